// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths, the buffered long-result entry type and a small
// helper used by the register-file write-back arbiter and its FIFO.
//   DW         data width
//   AW         register address width
//   NREG       number of architectural registers (2**AW)
//   wb_entry_t one long-unit result: destination register + data
package rf_wb_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 2 ** AW;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

  // Register 0 is hard-wired; writes to it are dropped everywhere.
  function automatic logic is_zero_rd(input logic [AW-1:0] rd);
    return (rd == '0);
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: small circular buffer for long-latency write-back results.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (drops all entries)
//   push         write push_data at the tail (ignored when full, unless
//                a pop happens in the same cycle)
//   push_data    entry to enqueue
//   pop          remove the head entry (ignored when empty)
//   head         current head entry (valid while !empty)
//   full, empty  occupancy flags
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the
  // index bits match.
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;
  entry_t      mem_q [DEPTH];

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
               (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
    head     = mem_q[rd_ptr_q[PW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: drives the register-file write port from the in-order
// pipeline and a buffered multi-cycle unit, and keeps a per-register busy
// scoreboard for decode.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   p_valid/p_rd/p_data     pipeline result (never stalled, highest priority)
//   l_valid/l_rd/l_data     long-unit result, accepted when l_ready
//   l_ready                 FIFO not full
//   iss_valid/iss_rd        long op issued this cycle (marks rd busy)
//   chk_rs1/chk_rs2         decode source registers to check
//   hazard                  decode must stall
//   busy                    scoreboard, bit 0 always 0
//   rf_we/rf_waddr/rf_wdata registered RF write port
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p_valid,
  input  logic [AW-1:0]   p_rd,
  input  logic [DW-1:0]   p_data,
  input  logic            l_valid,
  output logic            l_ready,
  input  logic [AW-1:0]   l_rd,
  input  logic [DW-1:0]   l_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   chk_rs1,
  input  logic [AW-1:0]   chk_rs2,
  output logic            hazard,
  output logic [NREG-1:0] busy,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata
);

  wb_entry_t       push_entry, head;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic            p_grant, pop_write;

  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  rf_wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (wb_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Slot arbitration: a pipeline write to r0 does not occupy the slot, so
  // the FIFO head may use it. Popped r0 entries are consumed silently.
  always_comb begin
    l_ready         = ~fifo_full;
    fifo_push       = l_valid & ~fifo_full;
    push_entry.rd   = l_rd;
    push_entry.data = l_data;

    p_grant   = p_valid & ~is_zero_rd(p_rd);
    fifo_pop  = ~p_grant & ~fifo_empty;
    pop_write = fifo_pop & ~is_zero_rd(head.rd);

    rf_we_d    = p_grant | pop_write;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (p_grant) begin
      rf_waddr_d = p_rd;
      rf_wdata_d = p_data;
    end else if (pop_write) begin
      rf_waddr_d = head.rd;
      rf_wdata_d = head.data;
    end

    // Clear is applied before set so a same-edge issue to the same rd wins.
    busy_d = busy_q;
    if (pop_write) busy_d[head.rd] = 1'b0;
    if (iss_valid && !is_zero_rd(iss_rd)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;

    hazard = busy_q[chk_rs1] | busy_q[chk_rs2] | (iss_valid & busy_q[iss_rd]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed testbench for rf_writeback with hand-computed expected values.
module tb_rf_writeback;
  import rf_wb_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            p_valid;
  logic [AW-1:0]   p_rd;
  logic [DW-1:0]   p_data;
  logic            l_valid;
  logic            l_ready;
  logic [AW-1:0]   l_rd;
  logic [DW-1:0]   l_data;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic [AW-1:0]   chk_rs1;
  logic [AW-1:0]   chk_rs2;
  logic            hazard;
  logic [NREG-1:0] busy;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;

  int vectors;
  int miscompares;

  rf_writeback #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p_valid   (p_valid),
    .p_rd      (p_rd),
    .p_data    (p_data),
    .l_valid   (l_valid),
    .l_ready   (l_ready),
    .l_rd      (l_rd),
    .l_data    (l_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .hazard    (hazard),
    .busy      (busy),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and logs misses.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives every input for the coming edge and lets combinational outputs settle.
  task automatic applyStimulus(input logic pv, input logic [AW-1:0] prd, input logic [DW-1:0] pd,
                               input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                               input logic iv, input logic [AW-1:0] ird,
                               input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    p_valid = pv; p_rd = prd; p_data = pd;
    l_valid = lv; l_rd = lrd; l_data = ld;
    iss_valid = iv; iss_rd = ird;
    chk_rs1 = rs1; chk_rs2 = rs2;
    #1;
  endtask

  // Advances past one rising edge and returns all inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    p_valid = 1'b0; p_rd = '0; p_data = '0;
    l_valid = 1'b0; l_rd = '0; l_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0;
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    checkOutput({tag, "_we"},   64'(rf_we),    64'(we));
    checkOutput({tag, "_addr"}, 64'(rf_waddr), 64'(addr));
    checkOutput({tag, "_data"}, 64'(rf_wdata), 64'(data));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    $display("[TB] reset state");
    checkWrite("rst", 1'b0, 5'd0, 32'h0);
    checkOutput("rst_l_ready", 64'(l_ready), 64'(1));
    checkOutput("rst_busy",    64'(busy),    64'(0));
    checkOutput("rst_hazard",  64'(hazard),  64'(0));

    $display("[TB] pipeline only");
    applyStimulus(1, 5'd3, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkWrite("pipe", 1'b1, 5'd3, 32'h1234);
    applyStimulus(1, 5'd0, 32'h5555, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkWrite("pipe_r0", 1'b0, 5'd3, 32'h1234);

    $display("[TB] long op");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    checkOutput("iss_hazard_pre", 64'(hazard), 64'(0));
    tick();
    checkOutput("iss_busy", 64'(busy), 64'(32'h0000_0080));
    applyStimulus(0, 0, 0, 1, 5'd7, 32'hDEAD, 0, 0, 5'd7, 0);
    checkOutput("long_hazard", 64'(hazard), 64'(1));
    checkOutput("long_l_ready", 64'(l_ready), 64'(1));
    tick();
    checkOutput("long_accept_we", 64'(rf_we), 64'(0));
    checkOutput("long_accept_busy", 64'(busy), 64'(32'h0000_0080));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    checkOutput("long_hazard_hold", 64'(hazard), 64'(1));
    tick();
    checkWrite("long_pop", 1'b1, 5'd7, 32'hDEAD);
    checkOutput("long_pop_busy", 64'(busy), 64'(0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
    checkOutput("long_hazard_drop", 64'(hazard), 64'(0));
    tick();
    checkOutput("long_idle_we", 64'(rf_we), 64'(0));

    $display("[TB] contention");
    applyStimulus(1, 5'd10, 32'h10, 1, 5'd20, 32'hA0, 0, 0, 0, 0);
    checkOutput("cont_ready0", 64'(l_ready), 64'(1));
    tick();
    checkWrite("cont_p10", 1'b1, 5'd10, 32'h10);
    applyStimulus(1, 5'd11, 32'h11, 1, 5'd21, 32'hA1, 0, 0, 0, 0);
    checkOutput("cont_ready1", 64'(l_ready), 64'(1));
    tick();
    checkWrite("cont_p11", 1'b1, 5'd11, 32'h11);
    applyStimulus(1, 5'd12, 32'h12, 1, 5'd22, 32'hA2, 0, 0, 0, 0);
    checkOutput("cont_ready2", 64'(l_ready), 64'(0));
    tick();
    checkWrite("cont_p12", 1'b1, 5'd12, 32'h12);
    applyStimulus(1, 5'd13, 32'h13, 1, 5'd22, 32'hA2, 0, 0, 0, 0);
    checkOutput("cont_ready3", 64'(l_ready), 64'(0));
    tick();
    checkWrite("cont_p13", 1'b1, 5'd13, 32'h13);
    applyStimulus(0, 0, 0, 1, 5'd22, 32'hA2, 0, 0, 0, 0);
    checkOutput("cont_ready4", 64'(l_ready), 64'(0));
    tick();
    checkWrite("drain0", 1'b1, 5'd20, 32'hA0);
    applyStimulus(0, 0, 0, 1, 5'd22, 32'hA2, 0, 0, 0, 0);
    checkOutput("cont_ready5", 64'(l_ready), 64'(1));
    tick();
    checkWrite("drain1", 1'b1, 5'd21, 32'hA1);
    tick();
    checkWrite("drain2", 1'b1, 5'd22, 32'hA2);
    tick();
    checkOutput("drain_done_we", 64'(rf_we), 64'(0));
    checkOutput("drain_done_ready", 64'(l_ready), 64'(1));

    $display("[TB] same-edge set and clear");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0);
    tick();
    checkOutput("sc_busy_set", 64'(busy), 64'(32'h0000_0200));
    applyStimulus(0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd9);
    tick();
    checkWrite("sc_pop", 1'b1, 5'd9, 32'h99);
    checkOutput("sc_busy_kept", 64'(busy), 64'(32'h0000_0200));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9);
    checkOutput("sc_hazard", 64'(hazard), 64'(1));
    applyStimulus(0, 0, 0, 1, 5'd9, 32'h98, 0, 0, 0, 0);
    tick();
    tick();
    checkWrite("sc_second_pop", 1'b1, 5'd9, 32'h98);
    checkOutput("sc_busy_clear", 64'(busy), 64'(0));

    $display("[TB] zero destination");
    applyStimulus(0, 0, 0, 1, 5'd0, 32'hBAD, 0, 0, 0, 0);
    checkOutput("z_ready", 64'(l_ready), 64'(1));
    tick();
    checkOutput("z_accept_we", 64'(rf_we), 64'(0));
    checkOutput("z_accept_busy", 64'(busy), 64'(0));
    tick();
    checkWrite("z_pop", 1'b0, 5'd9, 32'h98);
    checkOutput("z_pop_busy", 64'(busy), 64'(0));
    checkOutput("z_pop_ready", 64'(l_ready), 64'(1));

    $display("[TB] reset mid-stream");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0);
    tick();
    applyStimulus(1, 5'd1, 32'h1, 1, 5'd5, 32'h55, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 5'd2, 32'h2, 1, 5'd6, 32'h66, 0, 0, 0, 0);
    tick();
    checkOutput("mr_full", 64'(l_ready), 64'(0));
    checkOutput("mr_busy", 64'(busy), 64'(32'h0000_0020));
    checkWrite("mr_pre", 1'b1, 5'd2, 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    checkWrite("mr_rst", 1'b0, 5'd0, 32'h0);
    checkOutput("mr_rst_busy", 64'(busy), 64'(0));
    checkOutput("mr_rst_ready", 64'(l_ready), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("mr_no_write", 64'(rf_we), 64'(0));
    end
    checkOutput("mr_final_busy", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-back arbiter that drives the register file write port (we/waddr/wdata) from two producers: the in-order pipeline WB result and a multi-cycle unit (loads/divider) with a valid/ready handshake. Long-latency results are buffered in a small FIFO and merged into idle write slots. A per-register busy scoreboard tells the decode stage when a source or destination is still pending.

## Interface
- DW, 32, data width
- AW, 5, register address width (NREG = 2**AW)
- DEPTH, 2, long-result FIFO entries (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- p_valid  in  1  pipeline result valid this cycle; never stalled
- p_rd  in  AW  pipeline destination
- p_data  in  DW  pipeline result
- l_valid  in  1  long-unit result valid
- l_ready  out  1  FIFO can accept (= not full)
- l_rd  in  AW  long-unit destination
- l_data  in  DW  long-unit result
- iss_valid  in  1  long op issued this cycle
- iss_rd  in  AW  its destination
- chk_rs1, chk_rs2  in  AW  decode source registers
- hazard  out  1  combinational: busy[chk_rs1] | busy[chk_rs2] | (iss_valid & busy[iss_rd])
- busy  out  NREG  scoreboard; bit 0 tied 0
- rf_we  out  1  write enable to RF
- rf_waddr  out  AW  write address
- rf_wdata  out  DW  write data

## Operation
- Long results: accepted when l_valid & l_ready at a rising edge; pushed to FIFO, including rd==0 entries.
- Slot arbitration each cycle: pipeline has absolute priority when p_valid & p_rd≠0. Otherwise the FIFO head (if non-empty) is popped.
- Popped entry with rd==0 is discarded: no write, no scoreboard change.
- Output register: a granted write loads rf_we=1, rf_waddr, rf_wdata at the edge. With no grant, rf_we=0 and addr/data hold their last value.
- p_valid with p_rd==0 is ignored and frees the slot for the FIFO.
- Push and pop in the same cycle is allowed when full. Occupancy is unchanged, and l_ready stays low that cycle because it is not derived from the pop.
- Scoreboard:
  - iss_valid & iss_rd≠0 sets busy[iss_rd].
  - A FIFO pop granted to rd≠0 clears busy[rd].
  - Set and clear of the same rd in one edge: set wins.
  - Pipeline writes never touch busy.
- Upstream contract: no issue or pipeline write to a busy rd; decode stalls on hazard. The block does not reorder or check WAW.
- Widths: FIFO pointers are log2(DEPTH)+1 bits, with full/empty taken from the MSB compare. No arithmetic on data.

## Timing
- Reset (async assert, sync release) sets:
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - FIFO empty, so l_ready=1
  - busy=0, hazard=0
- Reset mid-operation drops all buffered entries and clears busy. No write is emitted for dropped entries.
- Pipeline latency: result sampled at edge N, rf_we high during cycle N+1, RF captures it at edge N+1.
- Long latency, FIFO empty and pipeline idle:
  - accepted at edge N
  - popped and registered at edge N+1
  - rf_we high during cycle N+1→N+2
  - busy cleared at edge N+1
- Throughput: one RF write per cycle. With a continuous pipeline stream, the FIFO fills and l_ready falls after DEPTH accepts.
- l_ready and hazard are combinational from registered state and inputs; no other combinational paths exist.

## Structure
- Package rf_wb_pkg:
  - DW, AW, NREG constants
  - typedef wb_entry_t {rd, data}
  - function is_zero_rd
- Sub-module rf_wb_fifo:
  - parameterised DEPTH and entry type
  - push/pop/full/empty ports, head data output
  - async active-low reset
- Top holds the arbiter, output register and scoreboard.

## Test plan
- Reset mid-stream: with 2 FIFO entries and busy[5]=1, pulse rst_n low. Then rf_we=0, busy=0, l_ready=1, and no write to r5 appears afterwards.
- Pipeline only: p_valid with r3=0x1234 at edge N. Then rf_we=1, waddr=3, wdata=0x1234 during cycle N+1. A second case with p_rd=0 gives rf_we=0.
- Long op: iss r7 sets busy[7], and chk_rs1=7 raises hazard. Later l_valid r7=0xDEAD is written one cycle after accept, busy[7] clears at the pop edge, and hazard drops.
- Contention: p_valid every cycle while 3 long results arrive. Then l_ready=0 after 2 accepts. When p_valid drops, writes drain in FIFO order with no loss or duplication.
- Same-edge set/clear: pop of r9 coincides with iss r9. Then busy[9] remains 1 and hazard is asserted for chk_rs2=9.
- Zero destination: a long result with rd=0 is accepted and popped. There is no rf_we, and busy[0] stays 0 throughout.
